// File: rtl/seq_mult.sv
// seq_mult: iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned,
// with valid/ready handshakes on both sides and one operation in flight.
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d, sum;
  logic [WIDTH-1:0]   mult_q, mult_d, mag_a, mag_b;
  logic               neg_q, neg_d, accept;
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE && in_valid) ? BUSY :
              (state_q == BUSY && cnt_q == LAST) ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  // Operands are reduced to magnitudes up front; the sign is reapplied once at the end.
  assign accept = in_valid && in_ready;
  assign mag_a  = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign mag_b  = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
  assign sum    = acc_q + (mult_q[0] ? mcand_q : '0);
  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (accept) begin
      cnt_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, mag_a};
      mult_d  = mag_b;
      acc_d   = '0;
      neg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q + 1'b1;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
      acc_d   = sum;
      if (cnt_q == LAST) product_d = neg_q ? -sum : sum;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  assign product = product_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed and scoreboarded checks of seq_mult at WIDTH 8, 32 and 2.
module tb_seq_mult;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        iv8 = 1'b0, ir8, sg8 = 1'b0, ov8, ordy8 = 1'b1, bz8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        iv32 = 1'b0, ir32, sg32 = 1'b0, ov32, bz32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] p32;
  logic        iv2 = 1'b0, ir2, sg2 = 1'b0, ov2, bz2;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [3:0]  p2;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_mult #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(sg8), .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(bz8));
  seq_mult #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(sg32), .out_valid(ov32), .out_ready(1'b1), .product(p32), .busy(bz32));
  seq_mult #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .is_signed(sg2), .out_valid(ov2), .out_ready(1'b1), .product(p2), .busy(bz2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] e, input string t);
    int n;
    a8 = x; b8 = y; sg8 = s; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 40) begin
      tick();
      n++;
    end
    check({t, "_lat"}, 64'(n), 64'd9);
    check({t, "_p"}, 64'(p8), 64'(e));
    tick();
    check({t, "_drain"}, {62'd0, ir8, ov8}, 64'b10);
  endtask
  initial begin
    logic [15:0] q[$];
    logic [15:0] ea, eb;
    int acc_n, rx_n, n;
    repeat (2) tick();
    check("rst_ir", 64'(ir8), 64'd1);
    check("rst_ov", 64'(ov8), 64'd0);
    check("rst_p", 64'(p8), 64'd0);
    check("rst_busy", 64'(bz8), 64'd0);
    rst_n = 1'b1;
    tick();
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3_5");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_m128");
    op8(8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80");
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128_127");
    op8(8'h00, 8'h00, 1'b1, 16'h0000, "s_zero");
    ordy8 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; sg8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 40) begin
      tick();
      n++;
    end
    check("bp_valid", 64'(ov8), 64'd1);
    for (int i = 0; i < 20; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
      tick();
      check("bp_hold_ov", 64'(ov8), 64'd1);
      check("bp_hold_p", 64'(p8), 64'h03A8);
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    tick();
    check("bp_release", {62'd0, ir8, ov8}, 64'b10);
    check("bp_old_p", 64'(p8), 64'h03A8);
    repeat (12) tick();
    check("bp_no_queue", {62'd0, bz8, ov8}, 64'b00);
    a8 = 8'h55; b8 = 8'h55; sg8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_state", {61'd0, ir8, ov8, bz8}, 64'b100);
    check("mid_rst_p", 64'(p8), 64'd0);
    op8(8'd6, 8'd7, 1'b0, 16'd42, "after_rst");
    acc_n = 0; rx_n = 0; n = 0;
    while ((acc_n < 100 || rx_n < acc_n) && n < 5000) begin
      iv8 = acc_n < 100;
      a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom); ordy8 = 1'($urandom);
      if (ov8 && ordy8) begin
        if (q.size() == 0) check("rnd_extra", 64'd1, 64'd0);
        else check("rnd_p", 64'(p8), 64'(q.pop_front()));
        rx_n++;
      end
      if (iv8 && ir8) begin
        ea = sg8 ? {{8{a8[7]}}, a8} : {8'h00, a8};
        eb = sg8 ? {{8{b8[7]}}, b8} : {8'h00, b8};
        q.push_back(16'(ea * eb));
        acc_n++;
      end
      tick();
      n++;
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    check("rnd_accepted", 64'(acc_n), 64'd100);
    check("rnd_received", 64'(rx_n), 64'd100);
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    n = 1;
    while (!ov32 && n < 80) begin
      tick();
      n++;
    end
    check("w32_lat", 64'(n), 64'd33);
    check("w32_p", p32, 64'hFFFF_FFFE_0000_0001);
    tick();
    a32 = 32'hFFFF_FFFF; b32 = 32'd2; sg32 = 1'b1; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    n = 1;
    while (!ov32 && n < 80) begin
      tick();
      n++;
    end
    check("w32_s_p", p32, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    a2 = 2'b10; b2 = 2'b10; sg2 = 1'b1; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    n = 1;
    while (!ov2 && n < 20) begin
      tick();
      n++;
    end
    check("w2_lat", 64'(n), 64'd3);
    check("w2_s_p", 64'(p2), 64'h4);
    tick();
    a2 = 2'b11; b2 = 2'b11; sg2 = 1'b0; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    n = 1;
    while (!ov2 && n < 20) begin
      tick();
      n++;
    end
    check("w2_u_p", 64'(p2), 64'h9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
